// File: rtl/aes_byte_loader.sv
// Byte-serial tagged host stream to wide key / S-box / data-block loader for the AES-128 core.
// Define AES_LOADER_SBOX_EN to compile in the 2048-bit S-box path (tag 01); otherwise tag 01 is rejected.
module aes_byte_loader #(
    parameter int KEY_W  = 128,
    parameter int DATA_W = 128,
    parameter int SBOX_W = 2048,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic [1:0]        byte_in_tag,
    input  logic              byte_in_vld,
    output logic              byte_in_rdy,
    output logic [KEY_W-1:0]  key_in,
    output logic              key_in_vld,
    output logic [SBOX_W-1:0] sbox_in,
    output logic              sbox_in_vld,
    output logic [DATA_W-1:0] data_in,
    output logic              data_in_vld,
    input  logic              data_accept,
    output logic              frame_err
);

    localparam logic [1:0] TAG_KEY  = 2'b00;
    localparam logic [1:0] TAG_DATA = 2'b10;
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_W / 8 - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W / 8 - 1);
`ifdef AES_LOADER_SBOX_EN
    localparam logic [1:0] TAG_SBOX = 2'b01;
    localparam logic [CNT_W-1:0] SBOX_LAST = CNT_W'(SBOX_W / 8 - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WAIT_ACC,
        ST_ISSUE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_tag;
    logic [1:0]        w_tag_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_rdy;
    logic              r_err;
    logic              w_err;
    logic              w_xfer;
    logic              w_load;
    logic              r_key_vld;
    logic              w_key_vld;
    logic              r_data_vld;
    logic              w_data_vld;
    logic [KEY_W-1:0]  r_key;
    logic [DATA_W-1:0] r_data;

    function automatic logic tag_ok(input logic [1:0] t);
`ifdef AES_LOADER_SBOX_EN
        return (t == TAG_KEY) || (t == TAG_DATA) || (t == TAG_SBOX);
`else
        return (t == TAG_KEY) || (t == TAG_DATA);
`endif
    endfunction

    function automatic logic [CNT_W-1:0] frame_last(input logic [1:0] t);
        case (t)
            TAG_DATA: return DATA_LAST;
`ifdef AES_LOADER_SBOX_EN
            TAG_SBOX: return SBOX_LAST;
`endif
            default:  return KEY_LAST;
        endcase
    endfunction

    assign w_xfer = byte_in_vld & r_rdy;

`ifdef AES_LOADER_SBOX_EN
    logic              r_sbox_vld;
    logic              w_sbox_vld;
    logic [SBOX_W-1:0] r_sbox;
`endif

    always_comb begin
        w_next_state = r_state;
        w_tag_next   = r_tag;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_err        = 1'b0;
        w_key_vld    = 1'b0;
        w_data_vld   = 1'b0;
`ifdef AES_LOADER_SBOX_EN
        w_sbox_vld   = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (tag_ok(byte_in_tag)) begin
                        w_load       = 1'b1;
                        w_tag_next   = byte_in_tag;
                        w_cnt_next   = CNT_W'(1);
                        w_next_state = ST_COLLECT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (w_xfer) begin
                    if (byte_in_tag == r_tag) begin
                        w_load = 1'b1;
                        if (r_cnt == frame_last(r_tag)) begin
                            w_cnt_next = '0;
                            if (r_tag == TAG_DATA) begin
                                w_next_state = ST_WAIT_ACC;
                            end else begin
                                w_next_state = ST_ISSUE;
`ifdef AES_LOADER_SBOX_EN
                                if (r_tag == TAG_SBOX) w_sbox_vld = 1'b1;
                                else                   w_key_vld  = 1'b1;
`else
                                w_key_vld = 1'b1;
`endif
                            end
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        // A foreign-tag byte aborts the frame; a legal one restarts a frame of its own type.
                        w_err = 1'b1;
                        if (tag_ok(byte_in_tag)) begin
                            w_load     = 1'b1;
                            w_tag_next = byte_in_tag;
                            w_cnt_next = CNT_W'(1);
                        end else begin
                            w_cnt_next   = '0;
                            w_next_state = ST_IDLE;
                        end
                    end
                end
            end
            ST_WAIT_ACC: begin
                if (data_accept) begin
                    w_data_vld   = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // rdy is decoded from the next state so it is registered and drops during reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag      <= TAG_KEY;
            r_cnt      <= '0;
            r_rdy      <= 1'b0;
            r_err      <= 1'b0;
            r_key_vld  <= 1'b0;
            r_data_vld <= 1'b0;
        end else begin
            r_tag      <= w_tag_next;
            r_cnt      <= w_cnt_next;
            r_rdy      <= (w_next_state == ST_IDLE) || (w_next_state == ST_COLLECT);
            r_err      <= w_err;
            r_key_vld  <= w_key_vld;
            r_data_vld <= w_data_vld;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_key  <= '0;
            r_data <= '0;
        end else if (w_load) begin
            if (byte_in_tag == TAG_KEY)  r_key  <= {r_key[KEY_W-9:0], byte_in};
            if (byte_in_tag == TAG_DATA) r_data <= {r_data[DATA_W-9:0], byte_in};
        end
    end

`ifdef AES_LOADER_SBOX_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sbox     <= '0;
            r_sbox_vld <= 1'b0;
        end else begin
            r_sbox_vld <= w_sbox_vld;
            if (w_load && byte_in_tag == TAG_SBOX) r_sbox <= {r_sbox[SBOX_W-9:0], byte_in};
        end
    end

    assign sbox_in     = r_sbox;
    assign sbox_in_vld = r_sbox_vld;
`else
    assign sbox_in     = '0;
    assign sbox_in_vld = 1'b0;
`endif

    assign byte_in_rdy = r_rdy;
    assign frame_err   = r_err;
    assign key_in      = r_key;
    assign key_in_vld  = r_key_vld;
    assign data_in     = r_data;
    assign data_in_vld = r_data_vld;

endmodule

// File: tb/tb_aes_byte_loader.sv
// Scoreboard bench for aes_byte_loader: a frame-level byte model predicts completed items and
// protocol errors; a negedge monitor pops and compares whenever the loader presents an output.
module tb_aes_byte_loader;

    localparam int KEY_W  = 128;
    localparam int DATA_W = 128;
    localparam int SBOX_W = 2048;
    localparam int CNT_W  = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        byte_in;
    logic [1:0]        byte_in_tag;
    logic              byte_in_vld;
    logic              byte_in_rdy;
    logic [KEY_W-1:0]  key_in;
    logic              key_in_vld;
    logic [SBOX_W-1:0] sbox_in;
    logic              sbox_in_vld;
    logic [DATA_W-1:0] data_in;
    logic              data_in_vld;
    logic              data_accept;
    logic              frame_err;

    logic acc_force;
    logic rand_acc;
    logic rnd_acc = 1'b1;

    int total   = 0;
    int bad     = 0;
    int exp_err = 0;
    int obs_err = 0;

    logic [KEY_W-1:0]  key_q[$];
    logic [DATA_W-1:0] data_q[$];
    logic [SBOX_W-1:0] sbox_q[$];

    bit         m_active = 1'b0;
    logic [1:0] m_tag = 2'b00;
    logic [7:0] m_bytes[$];

    aes_byte_loader #(
        .KEY_W (KEY_W),
        .DATA_W(DATA_W),
        .SBOX_W(SBOX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_in_tag(byte_in_tag),
        .byte_in_vld(byte_in_vld),
        .byte_in_rdy(byte_in_rdy),
        .key_in     (key_in),
        .key_in_vld (key_in_vld),
        .sbox_in    (sbox_in),
        .sbox_in_vld(sbox_in_vld),
        .data_in    (data_in),
        .data_in_vld(data_in_vld),
        .data_accept(data_accept),
        .frame_err  (frame_err)
    );

    always #5 clock = ~clock;

    assign data_accept = rand_acc ? rnd_acc : acc_force;

    always @(negedge clock) rnd_acc <= ($urandom_range(0, 3) != 0);

    function automatic bit tag_legal(input logic [1:0] t);
`ifdef AES_LOADER_SBOX_EN
        return t != 2'b11;
`else
        return (t == 2'b00) || (t == 2'b10);
`endif
    endfunction

    function automatic int frame_len(input logic [1:0] t);
        if (t == 2'b01) return SBOX_W / 8;
        if (t == 2'b10) return DATA_W / 8;
        return KEY_W / 8;
    endfunction

    // Reference: a frame is a run of same-tag bytes of the right length; anything else is an error.
    task automatic model_accept(input logic [7:0] b, input logic [1:0] t);
        logic [SBOX_W-1:0] v;
        if (m_active && t == m_tag) begin
            m_bytes.push_back(b);
        end else begin
            if (m_active || !tag_legal(t)) exp_err++;
            m_bytes.delete();
            m_active = tag_legal(t);
            m_tag    = t;
            if (m_active) m_bytes.push_back(b);
        end
        if (m_active && m_bytes.size() == frame_len(m_tag)) begin
            v = '0;
            foreach (m_bytes[i]) v = {v[SBOX_W-9:0], m_bytes[i]};
            if (m_tag == 2'b00)      key_q.push_back(v[KEY_W-1:0]);
            else if (m_tag == 2'b10) data_q.push_back(v[DATA_W-1:0]);
            else                     sbox_q.push_back(v);
            m_active = 1'b0;
            m_bytes.delete();
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] t);
        int w;
        w = 0;
        byte_in     = b;
        byte_in_tag = t;
        byte_in_vld = 1'b1;
        while (byte_in_rdy !== 1'b1 && w < 2000) begin
            @(negedge clock);
            w++;
        end
        if (byte_in_rdy !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte_in_rdy=%b after %0d cycles, required 1", byte_in_rdy, w);
            byte_in_vld = 1'b0;
            return;
        end
        @(posedge clock);
        model_accept(b, t);
        @(negedge clock);
        byte_in_vld = 1'b0;
    endtask

    always @(negedge clock) begin
        if (key_in_vld === 1'b1) begin
            if (key_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL key_unexpected: key_in_vld=1 key_in=%h, required no key pulse", key_in);
            end else begin
                chk("key_value", key_in, key_q.pop_front());
            end
        end
        if (data_in_vld === 1'b1) begin
            if (data_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL data_unexpected: data_in_vld=1 data_in=%h, required no data pulse", data_in);
            end else begin
                chk("data_value", data_in, data_q.pop_front());
            end
        end
        if (sbox_in_vld === 1'b1) begin
            if (sbox_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sbox_unexpected: sbox_in_vld=1, required no sbox pulse");
            end else begin
                logic [SBOX_W-1:0] e;
                e = sbox_q.pop_front();
                total++;
                if (sbox_in !== e) begin
                    bad++;
                    for (int i = 0; i < SBOX_W / 8; i++) begin
                        if (sbox_in[i*8 +: 8] !== e[i*8 +: 8]) begin
                            $display("FAIL sbox_value: byte %0d got %h, required %h", i, sbox_in[i*8 +: 8], e[i*8 +: 8]);
                            break;
                        end
                    end
                end
            end
        end
        if (frame_err === 1'b1) obs_err++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [1:0] t;
        int len;
        reset       = 1'b0;
        byte_in     = 8'h00;
        byte_in_tag = 2'b00;
        byte_in_vld = 1'b0;
        acc_force   = 1'b1;
        rand_acc    = 1'b0;

        #12;
        chk("rst_rdy", 128'(byte_in_rdy), 128'd0);
        chk("rst_key_vld", 128'(key_in_vld), 128'd0);
        chk("rst_data_vld", 128'(data_in_vld), 128'd0);
        chk("rst_sbox_vld", 128'(sbox_in_vld), 128'd0);
        chk("rst_err", 128'(frame_err), 128'd0);
        chk("rst_key", key_in, 128'd0);
        chk("rst_data", data_in, 128'd0);
        chk("rst_sbox", 128'(|sbox_in), 128'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rdy_after_reset", 128'(byte_in_rdy), 128'd1);

        // key load, back-to-back
        for (int i = 0; i < 16; i++) send(8'(i), 2'b00);
        chk("key_pulse_hi", 128'(key_in_vld), 128'd1);
        chk("key_const", key_in, 128'h000102030405060708090A0B0C0D0E0F);
        chk("key_rdy_issue", 128'(byte_in_rdy), 128'd0);
        chk("key_no_err", 128'(frame_err), 128'd0);
        @(negedge clock);
        chk("key_pulse_lo", 128'(key_in_vld), 128'd0);
        chk("key_rdy_back", 128'(byte_in_rdy), 128'd1);

        // data frame stalled by data_accept
        acc_force = 1'b0;
        for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i), 2'b10);
        for (int c = 0; c < 10; c++) begin
            chk("stall_rdy", 128'(byte_in_rdy), 128'd0);
            chk("stall_vld", 128'(data_in_vld), 128'd0);
            @(negedge clock);
        end
        acc_force = 1'b1;
        @(negedge clock);
        chk("stall_vld_hi", 128'(data_in_vld), 128'd1);
        chk("stall_data", data_in, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        @(negedge clock);
        chk("stall_vld_lo", 128'(data_in_vld), 128'd0);
        chk("stall_rdy_back", 128'(byte_in_rdy), 128'd1);

        // S-box stream
        e0 = obs_err;
        for (int i = 0; i < 256; i++) send(8'(i), 2'b01);
`ifdef AES_LOADER_SBOX_EN
        chk("sbox_vld_hi", 128'(sbox_in_vld), 128'd1);
        chk("sbox_msb", 128'(sbox_in[2047:2040]), 128'h00);
        chk("sbox_lsb", 128'(sbox_in[7:0]), 128'hFF);
        @(negedge clock);
        chk("sbox_vld_lo", 128'(sbox_in_vld), 128'd0);
        chk("sbox_no_err", 128'(obs_err - e0), 128'd0);
`else
        repeat (2) @(negedge clock);
        chk("sbox_off_errs", 128'(obs_err - e0), 128'd256);
        chk("sbox_off_zero", 128'(|sbox_in), 128'd0);
`endif
        repeat (2) @(negedge clock);
        chk("err_count_a", 128'(obs_err), 128'(exp_err));

        // tag switch mid-key
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 2'b00);
        send(8'h55, 2'b10);
        chk("switch_err", 128'(frame_err), 128'd1);
        for (int i = 0; i < 15; i++) send(8'h60 + 8'(i), 2'b10);
        @(negedge clock);
        chk("switch_data_vld", 128'(data_in_vld), 128'd1);
        chk("switch_data_msb", 128'(data_in[127:120]), 128'h55);
        @(negedge clock);

        // reserved tag in IDLE
        send(8'h77, 2'b11);
        chk("rsv_err_hi", 128'(frame_err), 128'd1);
        chk("rsv_rdy", 128'(byte_in_rdy), 128'd1);
        @(negedge clock);
        chk("rsv_err_lo", 128'(frame_err), 128'd0);
        chk("err_count_b", 128'(obs_err), 128'(exp_err));

        // reset mid-frame
        for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), 2'b00);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_key", key_in, 128'd0);
        chk("mid_rst_data", data_in, 128'd0);
        chk("mid_rst_rdy", 128'(byte_in_rdy), 128'd0);
        chk("mid_rst_vld", 128'({key_in_vld, data_in_vld, sbox_in_vld, frame_err}), 128'd0);
        m_active = 1'b0;
        m_bytes.delete();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 16; i++) send(8'($urandom), 2'b00);
        chk("mid_rst_key_vld", 128'(key_in_vld), 128'd1);
        @(negedge clock);

        // randomized frames, truncations, reserved tags and accept back-pressure
        rand_acc = 1'b1;
        for (int f = 0; f < 50; f++) begin
            t = 2'($urandom_range(0, 9) / 2);
            if (t == 2'b11 && $urandom_range(0, 1) == 0) t = 2'b01;
            if (t == 2'b11) begin
                len = 1;
            end else if (t == 2'b01 && !tag_legal(t)) begin
                len = $urandom_range(1, 3);
            end else if ($urandom_range(0, 3) == 0) begin
                len = $urandom_range(1, frame_len(t) - 1);
            end else begin
                len = frame_len(t);
            end
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 7) == 0) @(negedge clock);
                send(8'($urandom), t);
            end
        end
        rand_acc  = 1'b0;
        acc_force = 1'b1;
        repeat (6) @(negedge clock);

        chk("err_count_end", 128'(obs_err), 128'(exp_err));
        chk("key_q_drained", 128'(key_q.size()), 128'd0);
        chk("data_q_drained", 128'(data_q.size()), 128'd0);
        chk("sbox_q_drained", 128'(sbox_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
